cached_memory_system: RTL and testbench

//  Parametrised successor to the 6-bit/8-bit cache+RAM memory system. A direct-mapped cache

---
 rtl/cms_pkg.sv | 22 ++
 rtl/cms_backing_ram.sv | 51 +++++
 rtl/cached_memory_system.sv | 204 ++++++++++++++++++++
 tb/tb_cached_memory_system.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pkg.sv
// Shared types and geometry helpers for the cached memory system.
// The FSM state type and the tag/line-count derivations live here.
package cms_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_MEMWR,
        S_RESP
    } state_e;

    function automatic int unsigned cms_tag_w(input int unsigned addr_w, input int unsigned index_w);
        return addr_w - index_w;
    endfunction

    function automatic int unsigned cms_lines(input int unsigned index_w);
        return 32'd1 << index_w;
    endfunction

endpackage

// File: rtl/cms_backing_ram.sv
// Multi-cycle backing RAM: an access holds mem_en for MEM_LAT cycles and completes
// on the cycle mem_done is high; writes commit only on that final cycle.
module cms_backing_ram #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAST = LAT_W'(MEM_LAT - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LAT_W-1:0]  cnt_q;
    logic [LAT_W-1:0]  cnt_d;

    assign mem_done  = mem_en && (cnt_q == '0);
    assign mem_rdata = mem_q[mem_addr];

    // Remaining-cycles counter; reloads on completion so chained accesses stay aligned
    always_comb begin
        cnt_d = LAST;
        if (mem_en && !mem_done) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_done && mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: rtl/cached_memory_system.sv
// Direct-mapped cache in front of a multi-cycle RAM behind a valid/ready handshake,
// with selectable write-through or write-back policy and saturating hit/miss counters.
module cached_memory_system
    import cms_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned INDEX_W    = 3,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned WRITE_BACK = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rwb,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned TAG_W = cms_tag_w(ADDR_W, INDEX_W);
    localparam int unsigned LINES = cms_lines(INDEX_W);

    state_e            state_q;
    logic              rwb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              lookup_hit_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              hit_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               line_hit;
    logic               victim_dirty;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idx          = addr_q[INDEX_W-1:0];
    assign tag          = addr_q[ADDR_W-1:INDEX_W];
    assign line_hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty = (WRITE_BACK != 0) && valid_q[idx] && dirty_q[idx];

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign hit        = hit_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // EVICT writes the victim line back at its own address; FILL and MEMWR use the request
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            S_EVICT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx], idx};
                mem_wdata = data_q[idx];
            end
            S_FILL: begin
                mem_en = 1'b1;
            end
            S_MEMWR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    cms_backing_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_done (mem_done)
    );

    // Tag/data storage carries no reset; valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && rwb_q && line_hit) begin
            data_q[idx] <= wdata_q;
        end
        if (state_q == S_FILL && mem_done) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= rwb_q ? wdata_q : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rwb_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lookup_hit_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            hit_q        <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            hit_q       <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        rwb_q   <= rwb;
                        addr_q  <= address;
                        wdata_q <= data;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    lookup_hit_q <= line_hit;
                    if (line_hit) begin
                        hit_cnt_q <= sat_inc(hit_cnt_q);
                    end else begin
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                    end
                    if (rwb_q && WRITE_BACK == 0) begin
                        state_q <= S_MEMWR;
                    end else if (line_hit) begin
                        if (rwb_q) begin
                            dirty_q[idx] <= 1'b1;
                        end else begin
                            rsp_data_q <= data_q[idx];
                        end
                        rsp_valid_q <= 1'b1;
                        hit_q       <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        state_q <= victim_dirty ? S_EVICT : S_FILL;
                    end
                end
                S_EVICT: begin
                    if (mem_done) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_done) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= rwb_q;
                        rsp_data_q   <= rwb_q ? '0 : mem_rdata;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_MEMWR: begin
                    if (mem_done) begin
                        rsp_valid_q <= 1'b1;
                        hit_q       <= lookup_hit_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cached_memory_system.sv
// Bench for cached_memory_system: one write-through and one write-back instance,
// checked against a behavioural cache/RAM model with directed and random traffic.
module tb_cached_memory_system;

    localparam int M = 2;

    logic       clk;
    logic [1:0] rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rwb;
    logic [1:0] rsp_valid;
    logic [1:0] hit;
    logic [5:0] addr     [2];
    logic [7:0] wdata    [2];
    logic [7:0] rsp_data [2];
    logic [15:0] hc0, mc0;
    logic [3:0]  hc1, mc1;
    logic [15:0] hcnt [2];
    logic [15:0] mcnt [2];

    assign hcnt[0] = hc0;
    assign mcnt[0] = mc0;
    assign hcnt[1] = {12'b0, hc1};
    assign mcnt[1] = {12'b0, mc1};

    int checks = 0;
    int passed = 0;

    logic [7:0] m_ram  [2][64];
    logic [7:0] m_data [2][8];
    logic [2:0] m_tag  [2][8];
    bit         m_v    [2][8];
    bit         m_d    [2][8];
    int         m_hits [2];
    int         m_miss [2];
    int         cmax   [2] = '{65535, 15};

    cached_memory_system #(
        .ADDR_W(6), .DATA_W(8), .INDEX_W(3), .MEM_LAT(M), .WRITE_BACK(0), .CNT_W(16)
    ) dut_wt (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .rwb(rwb[0]), .address(addr[0]), .data(wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .hit(hit[0]), .hit_count(hc0), .miss_count(mc0)
    );

    cached_memory_system #(
        .ADDR_W(6), .DATA_W(8), .INDEX_W(3), .MEM_LAT(M), .WRITE_BACK(1), .CNT_W(4)
    ) dut_wb (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .rwb(rwb[1]), .address(addr[1]), .data(wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .hit(hit[1]), .hit_count(hc1), .miss_count(mc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: direct-mapped cache per instance; d==1 is write-back/allocate
    function automatic void model_access(input int d, input bit w, input logic [5:0] a,
                                         input logic [7:0] wd, output bit eh,
                                         output logic [7:0] ed, output int elat);
        int i = int'(a[2:0]);
        logic [2:0] t = a[5:3];
        bit wb = (d == 1);
        eh   = m_v[d][i] && (m_tag[d][i] == t);
        ed   = 8'h00;
        elat = 2;
        if (eh) begin
            if (m_hits[d] < cmax[d]) m_hits[d]++;
        end else begin
            if (m_miss[d] < cmax[d]) m_miss[d]++;
        end
        if (w && !wb) begin
            if (eh) m_data[d][i] = wd;
            m_ram[d][a] = wd;
            elat = 2 + M;
        end else if (eh) begin
            if (w) begin
                m_data[d][i] = wd;
                m_d[d][i] = 1'b1;
            end else begin
                ed = m_data[d][i];
            end
        end else begin
            elat = 2 + M;
            if (wb && m_v[d][i] && m_d[d][i]) begin
                m_ram[d][{m_tag[d][i], a[2:0]}] = m_data[d][i];
                elat = elat + M;
            end
            m_v[d][i]    = 1'b1;
            m_tag[d][i]  = t;
            m_d[d][i]    = w;
            m_data[d][i] = w ? wd : m_ram[d][a];
            ed           = w ? 8'h00 : m_ram[d][a];
        end
    endfunction

    function automatic void model_reset(input int d);
        for (int i = 0; i < 8; i++) begin
            m_v[d][i] = 1'b0;
            m_d[d][i] = 1'b0;
        end
        m_hits[d] = 0;
        m_miss[d] = 0;
    endfunction

    // One request: wait for ready (bounded), accept, measure edges to the rsp_valid sample
    task automatic do_req(input int d, input bit w, input logic [5:0] a, input logic [7:0] wd,
                          output bit got, output logic [7:0] rd, output bit rh, output int lat,
                          output bit eh, output logic [7:0] ed, output int elat);
        int k;
        got = 1'b0; rd = 8'h00; rh = 1'b0; lat = 0; eh = 1'b0; ed = 8'h00; elat = 0;
        req_valid[d] = 1'b1;
        rwb[d]       = w;
        addr[d]      = a;
        wdata[d]     = wd;
        k = 0;
        @(negedge clk);
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            req_valid[d] = 1'b0;
            return;
        end
        model_access(d, w, a, wd, eh, ed, elat);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                got = 1'b1;
                rd  = rsp_data[d];
                rh  = hit[d];
                lat = j + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int d);
        rst[d] = 1'b1;
        model_reset(d);
        @(posedge clk);
        @(posedge clk);
        #1 rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 2'b00;
        req_valid = 2'b00;
        rwb = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 6'h00;
            wdata[d] = 8'h00;
            model_reset(d);
        end
        #2 rst = 2'b11;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || hit[d] !== 1'b0 ||
                rsp_data[d] !== 8'h00 || hcnt[d] !== 16'h0 || mcnt[d] !== 16'h0)
                $display("FAIL reset_state[%0d]: ready=%b rsp_valid=%b hit=%b data=%h hc=%0d mc=%0d, want all 0",
                         d, req_ready[d], rsp_valid[d], hit[d], rsp_data[d], hcnt[d], mcnt[d]);
            else passed++;
        end
        @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b11) $display("FAIL ready_after_reset: got %b want 11", req_ready);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    // Loads RAM[a]=a^A0 through the DUT itself; the WB instance flushes its dirty lines after
    task automatic test_preload_saturation();
        bit got, rh, eh; logic [7:0] rd, ed; int lat, elat; int err;
        for (int d = 0; d < 2; d++) begin
            err = 0;
            for (int a = 0; a < 64; a++) begin
                do_req(d, 1'b1, 6'(a), 8'(a) ^ 8'hA0, got, rd, rh, lat, eh, ed, elat);
                if (!got || lat != elat) err++;
            end
            if (d == 1) begin
                for (int a = 0; a < 8; a++) begin
                    do_req(d, 1'b0, 6'(a), 8'h00, got, rd, rh, lat, eh, ed, elat);
                    if (!got || rd !== ed || lat != elat) err++;
                end
            end
            checks++;
            if (err != 0) $display("FAIL preload[%0d]: %0d bad responses, want 0", d, err);
            else passed++;
        end
        checks++;
        if (mcnt[1] !== 16'd15 || hcnt[1] !== 16'd0)
            $display("FAIL miss_saturation: mc=%0d hc=%0d, want mc=15 hc=0", mcnt[1], hcnt[1]);
        else passed++;
        checks++;
        if (mcnt[0] !== 16'(m_miss[0]) || mcnt[0] !== 16'd64)
            $display("FAIL wt_preload_misses: mc=%0d, want 64", mcnt[0]);
        else passed++;
        pulse_reset(0);
        pulse_reset(1);
    endtask

    task automatic test_read_miss_hit();
        bit got, rh, eh; logic [7:0] rd, ed; int lat, elat;
        do_req(0, 1'b0, 6'h05, 8'h00, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'hA5 || rh !== 1'b0 || lat != 4 || mcnt[0] !== 16'd1)
            $display("FAIL read_miss: got=%b data=%h hit=%b lat=%0d mc=%0d, want data=a5 hit=0 lat=4 mc=1",
                     got, rd, rh, lat, mcnt[0]);
        else passed++;
        do_req(0, 1'b0, 6'h05, 8'h00, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'hA5 || rh !== 1'b1 || lat != 2 || hcnt[0] !== 16'd1)
            $display("FAIL read_hit: got=%b data=%h hit=%b lat=%0d hc=%0d, want data=a5 hit=1 lat=2 hc=1",
                     got, rd, rh, lat, hcnt[0]);
        else passed++;
    endtask

    task automatic test_wb_write_evict();
        bit got, rh, eh; logic [7:0] rd, ed; int lat, elat;
        do_req(1, 1'b0, 6'h05, 8'h00, got, rd, rh, lat, eh, ed, elat);
        do_req(1, 1'b1, 6'h05, 8'h3C, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'h00 || rh !== 1'b1 || lat != 2)
            $display("FAIL wb_write_hit: got=%b data=%h hit=%b lat=%0d, want data=00 hit=1 lat=2",
                     got, rd, rh, lat);
        else passed++;
        checks++;
        if (dut_wb.u_ram.mem_q[5] !== 8'hA5)
            $display("FAIL wb_ram_unchanged: RAM[05]=%h want a5", dut_wb.u_ram.mem_q[5]);
        else passed++;
        do_req(1, 1'b0, 6'h0D, 8'h00, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'hAD || rh !== 1'b0 || lat != 6)
            $display("FAIL wb_dirty_evict: got=%b data=%h hit=%b lat=%0d, want data=ad hit=0 lat=6",
                     got, rd, rh, lat);
        else passed++;
        checks++;
        if (dut_wb.u_ram.mem_q[5] !== 8'h3C)
            $display("FAIL wb_writeback: RAM[05]=%h want 3c", dut_wb.u_ram.mem_q[5]);
        else passed++;
    endtask

    task automatic test_wt_write_noalloc();
        bit got, rh, eh; logic [7:0] rd, ed; int lat, elat;
        do_req(0, 1'b1, 6'h12, 8'h77, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'h00 || rh !== 1'b0 || lat != 4 || dut_wt.u_ram.mem_q[18] !== 8'h77)
            $display("FAIL wt_write_miss: got=%b data=%h hit=%b lat=%0d ram=%h, want data=00 hit=0 lat=4 ram=77",
                     got, rd, rh, lat, dut_wt.u_ram.mem_q[18]);
        else passed++;
        do_req(0, 1'b0, 6'h12, 8'h00, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'h77 || rh !== 1'b0 || lat != 4)
            $display("FAIL wt_no_allocate: got=%b data=%h hit=%b lat=%0d, want data=77 hit=0 lat=4",
                     got, rd, rh, lat);
        else passed++;
    endtask

    task automatic test_reset_midop();
        bit got, rh, eh; logic [7:0] rd, ed; int lat, elat; int k, seen;
        req_valid[0] = 1'b1;
        rwb[0] = 1'b0;
        addr[0] = 6'h2B;
        k = 0;
        @(negedge clk);
        while (!req_ready[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst[0] = 1'b1;
        model_reset(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0)
                $display("FAIL midop_in_reset: ready=%b rsp_valid=%b, want 0 0", req_ready[0], rsp_valid[0]);
            else passed++;
        end
        @(posedge clk);
        #1 rst[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (seen != 0 || hcnt[0] !== 16'd0 || mcnt[0] !== 16'd0)
            $display("FAIL midop_dropped: responses=%0d hc=%0d mc=%0d, want 0 0 0", seen, hcnt[0], mcnt[0]);
        else passed++;
        do_req(0, 1'b0, 6'h2B, 8'h00, got, rd, rh, lat, eh, ed, elat);
        checks++;
        if (!got || rd !== 8'h8B || rh !== 1'b0 || lat != 4)
            $display("FAIL midop_reread: got=%b data=%h hit=%b lat=%0d, want data=8b hit=0 lat=4",
                     got, rd, rh, lat);
        else passed++;
    endtask

    task automatic test_random(input int d);
        bit got, rh, eh, w; logic [7:0] rd, ed, wd; logic [5:0] a; int lat, elat; int err;
        err = 0;
        for (int n = 0; n < 40; n++) begin
            a  = 6'($urandom_range(0, 31));
            w  = ($urandom_range(0, 2) == 0);
            wd = 8'($urandom);
            do_req(d, w, a, wd, got, rd, rh, lat, eh, ed, elat);
            checks++;
            if (!got || rd !== ed || rh !== eh || lat != elat) begin
                $display("FAIL random[%0d] op=%0d w=%b a=%h: got=%b data=%h hit=%b lat=%0d, want data=%h hit=%b lat=%0d",
                         d, n, w, a, got, rd, rh, lat, ed, eh, elat);
                err++;
            end else passed++;
        end
        checks++;
        if (hcnt[d] !== 16'(m_hits[d]) || mcnt[d] !== 16'(m_miss[d]))
            $display("FAIL random_counters[%0d]: hc=%0d mc=%0d, want %0d %0d",
                     d, hcnt[d], mcnt[d], m_hits[d], m_miss[d]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] e;
        bit eh, acc; logic [7:0] ed; int elat;
        int accepted, responses, cyc, viol, bad;
        pulse_reset(0);
        accepted = 0; responses = 0; cyc = 0; viol = 0; bad = 0;
        req_valid[0] = 1'b1;
        rwb[0] = 1'b0;
        addr[0] = 6'($urandom_range(0, 15));
        while ((accepted < 10 || responses < accepted) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid[0]) begin
                responses++;
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if ({hit[0], rsp_data[0]} !== e) bad++;
                end
            end
            if (accepted > responses && req_ready[0]) viol++;
            acc = req_valid[0] && req_ready[0];
            if (acc) begin
                model_access(0, 1'b0, addr[0], 8'h00, eh, ed, elat);
                exp_q.push_back({eh, ed});
                accepted++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (accepted == 10) req_valid[0] = 1'b0;
                else addr[0] = 6'($urandom_range(0, 15));
            end
        end
        req_valid[0] = 1'b0;
        checks++;
        if (responses != 10 || accepted != 10 || cyc >= 300)
            $display("FAIL b2b_count: accepted=%0d responses=%0d cycles=%0d, want 10 10 <300",
                     accepted, responses, cyc);
        else passed++;
        checks++;
        if (bad != 0 || viol != 0)
            $display("FAIL b2b_data: bad=%0d ready_while_busy=%0d, want 0 0", bad, viol);
        else passed++;
        checks++;
        if (hcnt[0] + mcnt[0] !== 16'd10 || hcnt[0] !== 16'(m_hits[0]))
            $display("FAIL b2b_counters: hc=%0d mc=%0d, want sum 10 hc=%0d", hcnt[0], mcnt[0], m_hits[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_preload_saturation();
        test_read_miss_hit();
        test_wb_write_evict();
        test_wt_write_noalloc();
        test_reset_midop();
        test_random(0);
        test_random(1);
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
